counter_down_seq: RTL and testbench

- Loadable down-counter with a start/busy/done handshake. It is the count-down counterpart of the team's free-running up-counter with load.
- Sequences iteration indices d..0 for the sine/cosine datapath: loads a count on start, decrements on enable, and reports completion with a single-cycle done pulse.
- Sits between the top-level control FSM and the CORDIC stage that consumes the iteration index q.

---
 rtl/counter_down_seq_pkg.sv | 10 +
 rtl/counter_down_seq.sv | 68 ++++++
 tb/tb_counter_down_seq.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/counter_down_seq_pkg.sv
// Shared constants for the down-counter sequencer: state encoding and default width.
package counter_pkg;

    localparam int CNT_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/counter_down_seq.sv
// Loadable down-counter that sequences iteration indices d..0 with a
// start/busy/done handshake for the CORDIC stage.
module counter_down_seq
    import counter_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         enable,
    input  logic         abort,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         busy,
    output logic         done,
    output logic         iter_valid,
    output logic         max_tick,
    output logic         min_tick
);

    logic [1:0]   state_reg;
    logic [W-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            q_reg     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        q_reg     <= d;
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // abort outranks enable; a run that reaches 0 ends instead of wrapping
                    if (abort) begin
                        q_reg     <= '0;
                        state_reg <= ST_IDLE;
                    end else if (enable) begin
                        if (q_reg != '0) begin
                            q_reg <= q_reg - 1'b1;
                        end else begin
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    q_reg     <= '0;
                end
            endcase
        end
    end

    assign q          = q_reg;
    assign busy       = (state_reg == ST_RUN);
    assign done       = (state_reg == ST_DONE);
    assign iter_valid = busy & enable;
    assign max_tick   = &q_reg;
    assign min_tick   = ~|q_reg;

endmodule

// File: tb/tb_counter_down_seq.sv
// Directed vector bench for counter_down_seq: each row gives the inputs for one
// cycle and the outputs expected during that cycle, before its closing edge.
module tb_counter_down_seq;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic         enable;
    logic         abort;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic         busy;
    logic         done;
    logic         iter_valid;
    logic         max_tick;
    logic         min_tick;

    int n_cmp = 0;
    int n_bad = 0;

    counter_down_seq #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .enable     (enable),
        .abort      (abort),
        .d          (d),
        .q          (q),
        .busy       (busy),
        .done       (done),
        .iter_valid (iter_valid),
        .max_tick   (max_tick),
        .min_tick   (min_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         start;
        logic         enable;
        logic         abort;
        logic [W-1:0] d;
        logic [W-1:0] q;
        logic         busy;
        logic         done;
        logic         iv;
        logic         mx;
        logic         mn;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic s, input logic e, input logic a,
                                input logic [W-1:0] dd, input logic [W-1:0] eq,
                                input logic eb, input logic edn, input logic eiv,
                                input logic emx, input logic emn);
        vec_t v;
        v.rst = r; v.start = s; v.enable = e; v.abort = a; v.d = dd;
        v.q = eq; v.busy = eb; v.done = edn; v.iv = eiv; v.mx = emx; v.mn = emn;
        return v;
    endfunction

    task automatic drive(input logic r, input logic s, input logic e, input logic a,
                         input logic [W-1:0] dd);
        rst = r; start = s; enable = e; abort = a; d = dd;
        #2;
    endtask

    task automatic check_vec(input vec_t v, input string tag);
        drive(v.rst, v.start, v.enable, v.abort, v.d);
        n_cmp++;
        if ({q, busy, done, iter_valid, max_tick, min_tick} !==
            {v.q, v.busy, v.done, v.iv, v.mx, v.mn}) begin
            n_bad++;
            $display("FAIL %s: got q=%0d busy=%b done=%b iv=%b max=%b min=%b, want q=%0d busy=%b done=%b iv=%b max=%b min=%b",
                     tag, q, busy, done, iter_valid, max_tick, min_tick,
                     v.q, v.busy, v.done, v.iv, v.mx, v.mn);
        end else begin
            $display("%s ok: q=%0d busy=%b done=%b iv=%b", tag, q, busy, done, iter_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic got, input logic want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b", tag, got, want);
        end else begin
            $display("%s ok: %b", tag, got);
        end
    endtask

    initial begin
        int done_cycle;

        // reset held with start asserted: block must stay cleared
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0,1,1,0,4'd9, 4'd0,0,0,0,0,1));
        for (int i = 0; i < 2; i++) vecs.push_back(mk(1,0,0,0,4'd9, 4'd0,0,0,0,0,1));
        // full run d=5; start with d=3 mid-run and in the done cycle is ignored
        vecs.push_back(mk(1,1,1,0,4'd5, 4'd0,0,0,0,0,1));
        vecs.push_back(mk(1,0,1,0,4'd5, 4'd5,1,0,1,0,0));
        vecs.push_back(mk(1,0,1,0,4'd5, 4'd4,1,0,1,0,0));
        vecs.push_back(mk(1,1,1,0,4'd3, 4'd3,1,0,1,0,0));
        vecs.push_back(mk(1,0,1,0,4'd3, 4'd2,1,0,1,0,0));
        vecs.push_back(mk(1,0,1,0,4'd3, 4'd1,1,0,1,0,0));
        vecs.push_back(mk(1,0,1,0,4'd3, 4'd0,1,0,1,0,1));
        vecs.push_back(mk(1,1,1,0,4'd3, 4'd0,0,1,0,0,1));
        vecs.push_back(mk(1,0,1,0,4'd3, 4'd0,0,0,0,0,1));
        vecs.push_back(mk(1,0,1,0,4'd3, 4'd0,0,0,0,0,1));
        // enable gaps d=2, enable 1,0,1,0,1 during cycles 1..5
        vecs.push_back(mk(1,1,0,0,4'd2, 4'd0,0,0,0,0,1));
        vecs.push_back(mk(1,0,1,0,4'd2, 4'd2,1,0,1,0,0));
        vecs.push_back(mk(1,0,0,0,4'd2, 4'd1,1,0,0,0,0));
        vecs.push_back(mk(1,0,1,0,4'd2, 4'd1,1,0,1,0,0));
        vecs.push_back(mk(1,0,0,0,4'd2, 4'd0,1,0,0,0,1));
        vecs.push_back(mk(1,0,1,0,4'd2, 4'd0,1,0,1,0,1));
        vecs.push_back(mk(1,0,0,0,4'd2, 4'd0,0,1,0,0,1));
        vecs.push_back(mk(1,0,0,0,4'd2, 4'd0,0,0,0,0,1));
        // abort at q=3 (with enable), abort in idle/done harmless, restart accepted
        vecs.push_back(mk(1,1,1,0,4'd7, 4'd0,0,0,0,0,1));
        vecs.push_back(mk(1,0,1,0,4'd7, 4'd7,1,0,1,0,0));
        vecs.push_back(mk(1,0,1,0,4'd7, 4'd6,1,0,1,0,0));
        vecs.push_back(mk(1,0,1,0,4'd7, 4'd5,1,0,1,0,0));
        vecs.push_back(mk(1,0,1,0,4'd7, 4'd4,1,0,1,0,0));
        vecs.push_back(mk(1,0,1,1,4'd7, 4'd3,1,0,1,0,0));
        vecs.push_back(mk(1,0,1,1,4'd7, 4'd0,0,0,0,0,1));
        vecs.push_back(mk(1,1,1,1,4'd1, 4'd0,0,0,0,0,1));
        vecs.push_back(mk(1,0,1,0,4'd1, 4'd1,1,0,1,0,0));
        vecs.push_back(mk(1,0,1,0,4'd1, 4'd0,1,0,1,0,1));
        vecs.push_back(mk(1,0,1,1,4'd1, 4'd0,0,1,0,0,1));
        vecs.push_back(mk(1,0,1,0,4'd1, 4'd0,0,0,0,0,1));
        // d=0: single iteration
        vecs.push_back(mk(1,1,1,0,4'd0, 4'd0,0,0,0,0,1));
        vecs.push_back(mk(1,0,1,0,4'd0, 4'd0,1,0,1,0,1));
        vecs.push_back(mk(1,0,1,0,4'd0, 4'd0,0,1,0,0,1));
        vecs.push_back(mk(1,0,1,0,4'd0, 4'd0,0,0,0,0,1));
        // reset mid-run at q=4: cleared, no done
        vecs.push_back(mk(1,1,1,0,4'd6, 4'd0,0,0,0,0,1));
        vecs.push_back(mk(1,0,1,0,4'd6, 4'd6,1,0,1,0,0));
        vecs.push_back(mk(1,0,1,0,4'd6, 4'd5,1,0,1,0,0));
        vecs.push_back(mk(0,0,1,0,4'd6, 4'd4,1,0,1,0,0));
        vecs.push_back(mk(1,0,1,0,4'd6, 4'd0,0,0,0,0,1));
        vecs.push_back(mk(1,0,1,0,4'd6, 4'd0,0,0,0,0,1));

        drive(0, 0, 0, 0, '0);
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            check_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // d=15 full run: max_tick only in cycle 1, done in cycle 17
        drive(1, 1, 1, 0, 4'd15);
        @(posedge clk);
        #1;
        drive(1, 0, 1, 0, 4'd15);
        done_cycle = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc <= 16) begin
                n_cmp++;
                if (q !== 4'(16 - cyc) || busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL d15_cyc%0d: got q=%0d busy=%b, want q=%0d busy=1",
                             cyc, q, busy, 16 - cyc);
                end else begin
                    $display("d15_cyc%0d ok: q=%0d", cyc, q);
                end
                check_bit($sformatf("d15_max_cyc%0d", cyc), max_tick, (cyc == 1));
            end
            if (done) begin
                done_cycle = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (done_cycle != 17) begin
            n_bad++;
            $display("FAIL d15_done_cycle: got %0d, want 17", done_cycle);
        end else begin
            $display("d15_done_cycle ok: %0d", done_cycle);
        end
        check_bit("d15_done_not_busy", busy, 1'b0);

        // earliest restart: cycle after done is IDLE and accepts start
        @(posedge clk);
        #1;
        drive(1, 1, 1, 0, 4'd2);
        check_bit("restart_idle_done_low", done, 1'b0);
        @(posedge clk);
        #1;
        drive(1, 0, 1, 0, 4'd2);
        check_bit("restart_busy", busy, 1'b1);
        n_cmp++;
        if (q !== 4'd2) begin
            n_bad++;
            $display("FAIL restart_q: got %0d, want 2", q);
        end else begin
            $display("restart_q ok: %0d", q);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
